// File: rtl/decode_ctrl_pipe.sv
// Decode-stage controller: decodes the ID instruction, registers the control bundle into ID/EX and drives the IF/ID stall.
// Define RV_MEXT_EN to decode the M extension and hold EX for MD_LAT cycles per MD op.
module decode_ctrl_pipe #(
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned MD_LAT   = 4
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic [31:0]         inst_i,
  input  logic                inst_vld_i,
  input  logic                ex_flush_i,
  output logic                id_ready_o,
  output logic                ex_vld_o,
  output logic [3:0]          npc_op_o,
  output logic                rf_we_o,
  output logic [2:0]          rf_sel_o,
  output logic [2:0]          ext_op_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_a_sel_o,
  output logic                alu_b_sel_o,
  output logic [1:0]          ram_op_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic                ex_md_busy_o,
  output logic                ill_inst_o
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] NPC_JMP  = 4'd1;
  localparam logic [3:0] NPC_JALR = 4'd2;
  localparam logic [3:0] NPC_BEQ  = 4'd3;
  localparam logic [3:0] NPC_BNE  = 4'd4;
  localparam logic [3:0] NPC_BLT  = 4'd5;
  localparam logic [3:0] NPC_BGE  = 4'd6;
  localparam logic [3:0] NPC_BLTU = 4'd7;
  localparam logic [3:0] NPC_BGEU = 4'd8;

  localparam logic [2:0] RF_ALU  = 3'd1;
  localparam logic [2:0] RF_DRAM = 3'd2;
  localparam logic [2:0] RF_PC4  = 3'd3;
  localparam logic [2:0] RF_SEXT = 3'd4;

  localparam logic [2:0] EXT_R = 3'd0;
  localparam logic [2:0] EXT_I = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_U = 3'd4;
  localparam logic [2:0] EXT_J = 3'd5;

  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  if (MD_LAT < 1 || MD_LAT > 32) begin : g_bad_md_lat
    $error("MD_LAT must lie in 1..32");
  end

  typedef struct packed {
    logic                vld;
    logic                md;
    logic [3:0]          npc_op;
    logic                rf_we;
    logic [2:0]          rf_sel;
    logic [2:0]          ext_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_a_sel;
    logic                alu_b_sel;
    logic [1:0]          ram_op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign fun3   = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign fun7   = inst_i[31:25];

  ctrl_t dec;
  ctrl_t ctrl_d, ctrl_q;
  logic  legal, uses_rs1, uses_rs2, hazard, hold;
  logic  ill_d, ill_q;

  // Instruction decode into the ID/EX control bundle plus legality and operand usage
  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    dec.vld   = 1'b1;
    dec.rd    = rd;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    case (opcode)
      OPC_R: begin
        uses_rs2   = 1'b1;
        dec.rf_we  = 1'b1;
        dec.rf_sel = RF_ALU;
        dec.ext_op = EXT_R;
        dec.alu_op = ALU_OP_W'({1'b0, fun7[5], fun3});
        if (fun7 == 7'b0000000) legal = 1'b1;
        else if (fun7 == 7'b0100000) legal = (fun3 == 3'b000) || (fun3 == 3'b101);
`ifdef RV_MEXT_EN
        else if (fun7 == 7'b0000001) begin
          legal      = 1'b1;
          dec.md     = 1'b1;
          dec.rf_sel = 3'd5;
          dec.alu_op = ALU_OP_W'({1'b1, 1'b0, fun3});
        end
`endif
      end
      OPC_I: begin
        dec.rf_we     = 1'b1;
        dec.rf_sel    = RF_ALU;
        dec.ext_op    = EXT_I;
        dec.alu_b_sel = 1'b1;
        // fun7[5] is only an opcode bit for shifts; otherwise it is immediate data
        if (fun3 == 3'b001) begin
          legal      = (fun7 == 7'b0000000);
          dec.alu_op = ALU_OP_W'({1'b0, fun7[5], fun3});
        end else if (fun3 == 3'b101) begin
          legal      = (fun7 == 7'b0000000) || (fun7 == 7'b0100000);
          dec.alu_op = ALU_OP_W'({1'b0, fun7[5], fun3});
        end else begin
          legal      = 1'b1;
          dec.alu_op = ALU_OP_W'({2'b00, fun3});
        end
      end
      OPC_LOAD: begin
        legal         = fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.rf_we     = 1'b1;
        dec.rf_sel    = RF_DRAM;
        dec.ext_op    = EXT_I;
        dec.alu_b_sel = 1'b1;
        dec.ram_op    = RAM_READ;
      end
      OPC_STORE: begin
        legal         = fun3 inside {3'b000, 3'b001, 3'b010};
        uses_rs2      = 1'b1;
        dec.ext_op    = EXT_S;
        dec.alu_b_sel = 1'b1;
        dec.ram_op    = RAM_WRITE;
      end
      OPC_BRANCH: begin
        uses_rs2   = 1'b1;
        dec.ext_op = EXT_B;
        dec.alu_op = ALU_OP_W'(5'b01000);
        legal      = 1'b1;
        case (fun3)
          3'b000:  dec.npc_op = NPC_BEQ;
          3'b001:  dec.npc_op = NPC_BNE;
          3'b100:  dec.npc_op = NPC_BLT;
          3'b101:  dec.npc_op = NPC_BGE;
          3'b110:  dec.npc_op = NPC_BLTU;
          3'b111:  dec.npc_op = NPC_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal      = 1'b1;
        uses_rs1   = 1'b0;
        dec.rf_we  = 1'b1;
        dec.rf_sel = RF_SEXT;
        dec.ext_op = EXT_U;
      end
      OPC_AUIPC: begin
        legal         = 1'b1;
        uses_rs1      = 1'b0;
        dec.rf_we     = 1'b1;
        dec.rf_sel    = RF_ALU;
        dec.ext_op    = EXT_U;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
      end
      OPC_JAL: begin
        legal      = 1'b1;
        uses_rs1   = 1'b0;
        dec.npc_op = NPC_JMP;
        dec.rf_we  = 1'b1;
        dec.rf_sel = RF_PC4;
        dec.ext_op = EXT_J;
      end
      OPC_JALR: begin
        legal         = (fun3 == 3'b000);
        dec.npc_op    = NPC_JALR;
        dec.rf_we     = 1'b1;
        dec.rf_sel    = RF_PC4;
        dec.ext_op    = EXT_I;
        dec.alu_b_sel = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign hazard = inst_vld_i & ctrl_q.vld & (ctrl_q.ram_op == RAM_READ) & (ctrl_q.rd != 5'd0)
                & ((uses_rs1 & (rs1 == ctrl_q.rd)) | (uses_rs2 & (rs2 == ctrl_q.rd)));

`ifdef RV_MEXT_EN
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned MD_INIT = (MD_LAT > 1) ? MD_LAT - 2 : 0;

  typedef enum logic [0:0] {ST_RUN, ST_MD_BUSY} state_e;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  // Next ID/EX contents and stall, priority: flush > MD hold > load-use bubble > load
  always_comb begin
    ctrl_d     = '0;
    ill_d      = 1'b0;
    id_ready_o = 1'b1;
    hold       = 1'b0;
`ifdef RV_MEXT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    // A fresh MD op in EX under RUN is its first EX cycle; MD_BUSY covers the rest
    if (state_q == ST_RUN) hold = ctrl_q.md && (MD_LAT > 1);
    else                   hold = (cnt_q != '0);
`endif
    if (cpu_rst) begin
      id_ready_o = 1'b0;
    end else if (ex_flush_i) begin
`ifdef RV_MEXT_EN
      state_d = ST_RUN;
      cnt_d   = '0;
`endif
    end else if (hold) begin
      ctrl_d     = ctrl_q;
      id_ready_o = 1'b0;
`ifdef RV_MEXT_EN
      if (state_q == ST_RUN) begin
        state_d = ST_MD_BUSY;
        cnt_d   = CNT_W'(MD_INIT);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
`endif
    end else if (hazard) begin
      id_ready_o = 1'b0;
    end else begin
`ifdef RV_MEXT_EN
      state_d = ST_RUN;
      cnt_d   = '0;
`endif
      if (inst_vld_i) begin
        if (legal) ctrl_d = dec;
        else       ill_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ill_q  <= ill_d;
    end
  end

  assign ex_vld_o    = ctrl_q.vld;
  assign npc_op_o    = ctrl_q.npc_op;
  assign rf_we_o     = ctrl_q.rf_we;
  assign rf_sel_o    = ctrl_q.rf_sel;
  assign ext_op_o    = ctrl_q.ext_op;
  assign alu_op_o    = ctrl_q.alu_op;
  assign alu_a_sel_o = ctrl_q.alu_a_sel;
  assign alu_b_sel_o = ctrl_q.alu_b_sel;
  assign ram_op_o    = ctrl_q.ram_op;
  assign rd_o        = ctrl_q.rd;
  assign rs1_o       = ctrl_q.rs1;
  assign rs2_o       = ctrl_q.rs2;
  assign ill_inst_o  = ill_q;
  // md is only ever set by the M-extension decode, so this is constant 0 without it
  assign ex_md_busy_o = ctrl_q.md;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: instruction-level pipeline model checked every cycle, plus literal spot checks.
// Build with RV_MEXT_EN defined to exercise the multi-cycle MD issue path.
module tb_decode_ctrl_pipe;
  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned MD_LAT   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         inst;
  logic                inst_vld, flush;
  logic                id_ready, ex_vld, rf_we, a_sel, b_sel, md_busy, ill;
  logic [3:0]          npc_op;
  logic [2:0]          rf_sel, ext_op;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          ram_op;
  logic [4:0]          rd, rs1, rs2;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.ALU_OP_W(ALU_OP_W), .MD_LAT(MD_LAT)) dut (
    .cpu_clk(clk), .cpu_rst(rst), .inst_i(inst), .inst_vld_i(inst_vld), .ex_flush_i(flush),
    .id_ready_o(id_ready), .ex_vld_o(ex_vld), .npc_op_o(npc_op), .rf_we_o(rf_we),
    .rf_sel_o(rf_sel), .ext_op_o(ext_op), .alu_op_o(alu_op), .alu_a_sel_o(a_sel),
    .alu_b_sel_o(b_sel), .ram_op_o(ram_op), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .ex_md_busy_o(md_busy), .ill_inst_o(ill)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef enum int {K_ILL, K_R, K_MD, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR} kind_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] npc;
    logic       we;
    logic [2:0] sel;
    logic [2:0] ext;
    logic [4:0] alu;
    logic       a;
    logic       b;
    logic [1:0] ram;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } exp_t;

  function automatic kind_e classify(input logic [31:0] in);
    logic [6:0] op = in[6:0];
    logic [2:0] f3 = in[14:12];
    logic [6:0] f7 = in[31:25];
    case (op)
      7'h33: begin
        if (f7 == 7'h00) return K_R;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return K_R;
`ifdef RV_MEXT_EN
        if (f7 == 7'h01) return K_MD;
`endif
        return K_ILL;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? K_I : K_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? K_I : K_ILL;
        return K_I;
      end
      7'h03: return (f3 == 3'd3 || f3 > 3'd5) ? K_ILL : K_LD;
      7'h23: return (f3 < 3'd3) ? K_ST : K_ILL;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JAL;
      7'h67: return (f3 == 3'd0) ? K_JALR : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [31:0] in, input kind_e k);
    exp_t e = '0;
    logic [2:0] f3 = in[14:12];
    e.vld = 1'b1;
    e.rd  = in[11:7];
    e.rs1 = in[19:15];
    e.rs2 = in[24:20];
    case (k)
      K_R:     begin e.we = 1; e.sel = 3'd1; e.alu = {1'b0, in[30], f3}; end
      K_MD:    begin e.we = 1; e.sel = 3'd5; e.alu = {2'b10, f3}; end
      K_I:     begin e.we = 1; e.sel = 3'd1; e.ext = 3'd1; e.b = 1;
                     e.alu = {1'b0, (f3 == 3'd1 || f3 == 3'd5) ? in[30] : 1'b0, f3}; end
      K_LD:    begin e.we = 1; e.sel = 3'd2; e.ext = 3'd1; e.b = 1; e.ram = 2'd1; end
      K_ST:    begin e.ext = 3'd2; e.b = 1; e.ram = 2'd2; end
      K_BR:    begin
                 e.ext = 3'd3; e.alu = 5'b01000;
                 case (f3)
                   3'd0: e.npc = 4'd3;
                   3'd1: e.npc = 4'd4;
                   3'd4: e.npc = 4'd5;
                   3'd5: e.npc = 4'd6;
                   3'd6: e.npc = 4'd7;
                   default: e.npc = 4'd8;
                 endcase
               end
      K_LUI:   begin e.we = 1; e.sel = 3'd4; e.ext = 3'd4; end
      K_AUIPC: begin e.we = 1; e.sel = 3'd1; e.ext = 3'd4; e.a = 1; e.b = 1; end
      K_JAL:   begin e.we = 1; e.sel = 3'd3; e.ext = 3'd5; e.npc = 4'd1; end
      K_JALR:  begin e.we = 1; e.sel = 3'd3; e.ext = 3'd1; e.b = 1; e.npc = 4'd2; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Model of what sits in EX: its control bundle and how many EX cycles it has left
  exp_t  m = '0;
  logic  m_md = 1'b0;
  logic  m_ill = 1'b0;
  int    m_left = 0;
  bit    model_on = 1'b0;
  kind_e k;
  logic  u1, u2, haz, exp_rdy;
  exp_t  dut_vec;

  always @(negedge clk) begin
    if (model_on) begin
      k   = classify(inst);
      u1  = !(inst[6:0] inside {7'h37, 7'h17, 7'h6F});
      u2  = inst[6:0] inside {7'h33, 7'h23, 7'h63};
      haz = inst_vld && m.vld && m.ram == 2'd1 && m.rd != 5'd0 &&
            ((u1 && inst[19:15] == m.rd) || (u2 && inst[24:20] == m.rd));
      if (rst)             exp_rdy = 1'b0;
      else if (flush)      exp_rdy = 1'b1;
      else if (m_left > 1) exp_rdy = 1'b0;
      else                 exp_rdy = !haz;
      dut_vec = {ex_vld, npc_op, rf_we, rf_sel, ext_op, alu_op, a_sel, b_sel, ram_op, rd, rs1, rs2};
      chk("id_ready", 64'(id_ready), 64'(exp_rdy));
      chk("ex_bundle", 64'(dut_vec), 64'(m));
      chk("ex_md_busy", 64'(md_busy), 64'(m_md));
      chk("ill_inst", 64'(ill), 64'(m_ill));
      if (rst || flush) begin
        m = '0; m_md = 0; m_left = 0; m_ill = 0;
      end else if (m_left > 1) begin
        m_left--; m_ill = 0;
      end else if (haz || !inst_vld) begin
        m = '0; m_md = 0; m_left = 0; m_ill = 0;
      end else if (k == K_ILL) begin
        m = '0; m_md = 0; m_left = 0; m_ill = 1;
      end else begin
        m = expect_of(inst, k); m_md = (k == K_MD); m_ill = 0;
        m_left = m_md ? int'(MD_LAT) : 1;
      end
    end
  end

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD      = 32'h0020_81B3;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;
  localparam logic [31:0] ADD_X6   = 32'h0012_8333;
  localparam logic [31:0] LW_X8    = 32'h0001_2403;
  localparam logic [31:0] LUI      = 32'h1234_53B7;
  localparam logic [31:0] BLTU     = 32'h0020_E063;
  localparam logic [31:0] BGEU     = 32'h0020_F063;
  localparam logic [31:0] BR_ILL   = 32'h0020_A063;
  localparam logic [31:0] AUIPC    = 32'h0000_1217;
  localparam logic [31:0] JAL      = 32'h0000_00EF;
  localparam logic [31:0] JALR     = 32'h0000_8067;
  localparam logic [31:0] SW       = 32'h0020_A023;
  localparam logic [31:0] SUB      = 32'h4020_81B3;
  localparam logic [31:0] SRAI     = 32'h4030_D093;
  localparam logic [31:0] ADDI_B30 = 32'h4000_0093;
  localparam logic [31:0] LW_X0    = 32'h0000_A003;
  localparam logic [31:0] ADD_X0   = 32'h0010_0333;
  localparam logic [31:0] MUL      = 32'h0220_81B3;

  task automatic drive(input logic [31:0] in, input logic v, input logic f, input logic r);
    inst = in; inst_vld = v; flush = f; rst = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(NOP, 1'b0, 1'b0, 1'b1);
    tick;
    model_on = 1'b1;
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    tick;
    chk("rst_ex_vld", 64'(ex_vld), 64'd0);
    chk("rst_npc_op", 64'(npc_op), 64'd0);

    drive(ADD, 1, 0, 0);
    chk("add_ready", 64'(id_ready), 64'd1);
    tick;
    chk("add_ex_vld", 64'(ex_vld), 64'd1);
    chk("add_rf_we", 64'(rf_we), 64'd1);
    chk("add_rf_sel", 64'(rf_sel), 64'd1);
    chk("add_alu_op", 64'(alu_op), 64'd0);
    chk("add_regs", 64'({rd, rs1, rs2}), 64'({5'd3, 5'd1, 5'd2}));

    drive(LW_X5, 1, 0, 0); tick;
    drive(ADD_X6, 1, 0, 0);
    chk("ldu_stall", 64'(id_ready), 64'd0);
    tick;
    chk("ldu_bubble", 64'(ex_vld), 64'd0);
    chk("ldu_release", 64'(id_ready), 64'd1);
    tick;
    chk("ldu_add_issued", 64'({ex_vld, rd}), 64'({1'b1, 5'd6}));

    drive(LW_X8, 1, 0, 0); tick;
    drive(LUI, 1, 0, 0);
    chk("lui_no_stall", 64'(id_ready), 64'd1);
    tick;
    chk("lui_rf_sel", 64'(rf_sel), 64'd4);
    chk("lui_ext_op", 64'(ext_op), 64'd4);

    drive(LW_X5, 1, 0, 0); tick;
    drive(ADD_X6, 1, 1, 0);
    chk("flush_ready", 64'(id_ready), 64'd1);
    tick;
    chk("flush_bubble", 64'({ex_vld, rf_we, ram_op}), 64'd0);
    drive(ADD_X6, 1, 0, 0);
    chk("post_flush_ready", 64'(id_ready), 64'd1);
    tick;
    chk("post_flush_issue", 64'(ex_vld), 64'd1);

    drive(BLTU, 1, 0, 0); tick;
    chk("bltu_npc", 64'(npc_op), 64'd7);
    chk("bltu_alu", 64'(alu_op), 64'h08);
    drive(BGEU, 1, 0, 0); tick;
    chk("bgeu_npc", 64'(npc_op), 64'd8);
    drive(BR_ILL, 1, 0, 0); tick;
    chk("br_ill_flag", 64'({ill, ex_vld}), 64'({1'b1, 1'b0}));
    drive(AUIPC, 1, 0, 0); tick;
    chk("ill_one_cycle", 64'(ill), 64'd0);
    chk("auipc_fields", 64'({a_sel, ext_op, rf_sel}), 64'({1'b1, 3'd4, 3'd1}));
    drive(JAL, 1, 0, 0); tick;
    chk("jal_fields", 64'({npc_op, ext_op, rf_sel}), 64'({4'd1, 3'd5, 3'd3}));
    drive(JALR, 1, 0, 0); tick;
    drive(SW, 1, 0, 0); tick;
    chk("sw_fields", 64'({ram_op, rf_we}), 64'({2'd2, 1'b0}));
    drive(SUB, 1, 0, 0); tick;
    chk("sub_alu", 64'(alu_op), 64'h08);
    drive(SRAI, 1, 0, 0); tick;
    chk("srai_alu", 64'(alu_op), 64'h0D);
    drive(ADDI_B30, 1, 0, 0); tick;
    chk("addi_alu", 64'(alu_op), 64'h00);

    drive(LW_X0, 1, 0, 0); tick;
    drive(ADD_X0, 1, 0, 0);
    chk("rd0_no_stall", 64'(id_ready), 64'd1);
    tick;
    drive(LW_X5, 1, 0, 0); tick;
    drive(ADD_X6, 0, 0, 0);
    chk("invalid_no_stall", 64'(id_ready), 64'd1);
    tick;
    chk("invalid_bubble", 64'(ex_vld), 64'd0);

`ifdef RV_MEXT_EN
    drive(MUL, 1, 0, 0); tick;
    chk("mul_alu", 64'(alu_op), 64'h10);
    drive(ADD, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("md_hold_ready", 64'(id_ready), 64'd0);
      chk("md_hold_busy", 64'(md_busy), 64'd1);
      tick;
    end
    chk("md_last_ready", 64'(id_ready), 64'd1);
    chk("md_last_busy", 64'(md_busy), 64'd1);
    tick;
    chk("md_done", 64'({md_busy, alu_op}), 64'd0);
    drive(MUL, 1, 0, 0); tick;
    drive(NOP, 0, 0, 0); tick;
    chk("md_busy_mid", 64'(md_busy), 64'd1);
    drive(NOP, 0, 0, 1);
    chk("md_rst_ready", 64'(id_ready), 64'd0);
    tick;
    chk("md_rst_clear", 64'({ex_vld, md_busy, alu_op}), 64'd0);
`else
    drive(MUL, 1, 0, 0); tick;
    chk("mul_illegal", 64'({ill, ex_vld, md_busy}), 64'({1'b1, 1'b0, 1'b0}));
    drive(ADD, 1, 0, 0); tick;
    chk("mul_ill_clear", 64'(ill), 64'd0);
    drive(NOP, 0, 0, 1);
    chk("mid_rst_ready", 64'(id_ready), 64'd0);
    tick;
    chk("mid_rst_clear", 64'({ex_vld, rf_we}), 64'd0);
`endif
    drive(ADD, 1, 0, 0);
    chk("after_rst_ready", 64'(id_ready), 64'd1);
    tick;
    chk("after_rst_issue", 64'(ex_vld), 64'd1);
    drive(NOP, 0, 0, 0);
    tick;
    tick;
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
